ring_phase_monitor: RTL and testbench

Downstream consumer of the WIDTH-bit one-hot ring counter output.
- Samples the ring each clock and encodes it to a binary phase index.
- Checks one-hot legality and correct rotate-right stepping.
- Acquires lock after a run of legal steps, then counts completed revolutions for the downstream sequencer.
- Reports sticky faults.

---
 rtl/ring_pkg.sv | 18 +
 rtl/ring_onehot_enc.sv | 29 ++
 rtl/ring_phase_monitor.sv | 126 ++++++++++++
 tb/tb_ring_phase_monitor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring phase monitor.
package ring_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    // Index width for a WIDTH-bit one-hot vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot encoder: binary index of the set bit plus an exactly-one-hot flag.
module ring_onehot_enc
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] ones;
    logic [IDX_W-1:0] pos;

    always_comb begin
        ones = '0;
        pos  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CNT_W'(vec[i]);
            if (vec[i]) pos = IDX_W'(i);
        end
        valid_c = (ones == CNT_W'(1));
        idx_c   = valid_c ? pos : '0;
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Monitors a one-hot rotate-right ring: encodes phase, checks stepping, locks and counts revolutions.
// Optional RING_MON_HOLD_EN: a repeated one-hot sample is accepted as a legal stall.
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_STEPS = 8,
    parameter int unsigned REV_W      = 8,
    localparam int unsigned IDX_W     = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             err_clr,
    output logic [IDX_W-1:0] phase_idx,
    output logic             phase_valid,
    output logic             locked,
    output logic             wrap_pulse,
    output logic [REV_W-1:0] rev_count,
    output logic             err_onehot,
    output logic             err_skip
);

    localparam int unsigned STEP_W = $clog2(LOCK_STEPS + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ring_q;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [REV_W-1:0]   rev_d;
    logic               wrap_d, err_oh_d, err_sk_d;
    logic [IDX_W-1:0]   cur_idx_c;
    logic               cur_valid_c;
    logic               rot_ok_c, hold_ok_c, step_ok_c;

    ring_onehot_enc #(.WIDTH(WIDTH)) u_enc (
        .vec     (ring_in),
        .idx_c   (cur_idx_c),
        .valid_c (cur_valid_c)
    );

    // phase_valid is the registered one-hot flag of the previous sample.
    assign rot_ok_c = cur_valid_c && phase_valid &&
                      (ring_in == {ring_q[0], ring_q[WIDTH-1:1]});
`ifdef RING_MON_HOLD_EN
    assign hold_ok_c = cur_valid_c && phase_valid && (ring_in == ring_q);
`else
    assign hold_ok_c = 1'b0;
`endif
    assign step_ok_c = rot_ok_c || hold_ok_c;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        rev_d    = rev_count;
        wrap_d   = 1'b0;
        // err_clr clears first so an error detected on the same edge still sets its flag.
        err_oh_d = err_clr ? 1'b0 : err_onehot;
        err_sk_d = err_clr ? 1'b0 : err_skip;
        unique case (state_q)
            ACQUIRE: begin
                if (cur_valid_c) begin
                    state_d = TRACK;
                    step_d  = '0;
                end
            end
            TRACK: begin
                if (rot_ok_c) begin
                    step_d = step_q + STEP_W'(1);
                    if (step_d >= STEP_W'(LOCK_STEPS)) state_d = LOCKED;
                end else if (!step_ok_c) begin
                    err_oh_d = err_oh_d | ~cur_valid_c;
                    err_sk_d = err_sk_d |  cur_valid_c;
                    state_d  = ACQUIRE;
                end
            end
            LOCKED: begin
                if (rot_ok_c) begin
                    if (ring_q[0]) begin
                        wrap_d = 1'b1;
                        rev_d  = rev_count + REV_W'(1);
                    end
                end else if (!step_ok_c) begin
                    err_oh_d = err_oh_d | ~cur_valid_c;
                    err_sk_d = err_sk_d |  cur_valid_c;
                    state_d  = FAULT;
                end
            end
            FAULT: begin
                // Already faulted: no new error detection, only recovery via err_clr.
                if (err_clr) begin
                    state_d = ACQUIRE;
                    step_d  = '0;
                    rev_d   = '0;
                end
            end
            default: state_d = ACQUIRE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACQUIRE;
            ring_q      <= '0;
            step_q      <= '0;
            phase_idx   <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            wrap_pulse  <= 1'b0;
            rev_count   <= '0;
            err_onehot  <= 1'b0;
            err_skip    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ring_q      <= ring_in;
            step_q      <= step_d;
            phase_idx   <= cur_idx_c;
            phase_valid <= cur_valid_c;
            locked      <= (state_d == LOCKED);
            wrap_pulse  <= wrap_d;
            rev_count   <= rev_d;
            err_onehot  <= err_oh_d;
            err_skip    <= err_sk_d;
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: directed scenarios plus randomized stream vs. a phase-arithmetic model.
module tb_ring_phase_monitor;

    localparam int W  = 4;
    localparam int LS = 8;
    localparam int RW = 2;
`ifdef RING_MON_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    localparam int M_ACQ = 0;
    localparam int M_TRK = 1;
    localparam int M_LCK = 2;
    localparam int M_FLT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          err_clr;
    logic [W-1:0]  ring_in;
    logic [1:0]    phase_idx;
    logic          phase_valid, locked, wrap_pulse, err_onehot, err_skip;
    logic [RW-1:0] rev_count;

    ring_phase_monitor #(.WIDTH(W), .LOCK_STEPS(LS), .REV_W(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ring_in     (ring_in),
        .err_clr     (err_clr),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .locked      (locked),
        .wrap_pulse  (wrap_pulse),
        .rev_count   (rev_count),
        .err_onehot  (err_onehot),
        .err_skip    (err_skip)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int valid;
        int lck;
        int wrap;
        int rev;
        int eoh;
        int esk;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model state (phase arithmetic, not the RTL encoding).
    int           m_mode  = M_ACQ;
    logic [W-1:0] m_prev  = '0;
    int           m_steps = 0;
    int           m_rev   = 0;
    int           m_eoh   = 0;
    int           m_esk   = 0;
    int           ph      = 0;

    function automatic int bit_index(input logic [W-1:0] v);
        int r = 0;
        for (int i = 0; i < W; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [W-1:0] r, input bit clr, input bit rst);
        exp_t e;
        bit   oh, prev_oh, adv, stall;
        int   ci, pi, wrap;
        wrap = 0;
        if (rst) begin
            m_mode = M_ACQ; m_prev = '0; m_steps = 0; m_rev = 0; m_eoh = 0; m_esk = 0;
            e.idx = 0; e.valid = 0;
        end else begin
            oh      = ($countones(r) == 1);
            prev_oh = ($countones(m_prev) == 1);
            ci      = bit_index(r);
            pi      = bit_index(m_prev);
            adv     = oh && prev_oh && (ci == (pi + W - 1) % W);
            stall   = HOLD_EN && oh && prev_oh && (r == m_prev);
            if (clr) begin m_eoh = 0; m_esk = 0; end
            case (m_mode)
                M_ACQ: if (oh) begin m_mode = M_TRK; m_steps = 0; end
                M_TRK: begin
                    if (adv) begin
                        m_steps++;
                        if (m_steps >= LS) m_mode = M_LCK;
                    end else if (!stall) begin
                        if (!oh) m_eoh = 1; else m_esk = 1;
                        m_mode = M_ACQ;
                    end
                end
                M_LCK: begin
                    if (adv) begin
                        if (pi == 0) begin wrap = 1; m_rev = (m_rev + 1) % (1 << RW); end
                    end else if (!stall) begin
                        if (!oh) m_eoh = 1; else m_esk = 1;
                        m_mode = M_FLT;
                    end
                end
                default: if (clr) begin m_mode = M_ACQ; m_rev = 0; end
            endcase
            m_prev  = r;
            e.idx   = oh ? ci : 0;
            e.valid = oh ? 1 : 0;
        end
        e.lck  = (m_mode == M_LCK) ? 1 : 0;
        e.wrap = wrap;
        e.rev  = m_rev;
        e.eoh  = m_eoh;
        e.esk  = m_esk;
        q.push_back(e);
    endtask

    // Drive one sample at the falling edge and queue its expected response.
    task automatic drive(input logic [W-1:0] r, input bit clr, input bit rst);
        @(negedge clk);
        ring_in = r;
        err_clr = clr;
        reset   = rst;
        model(r, clr, rst);
        if ($countones(r) == 1) ph = (bit_index(r) + W - 1) % W;
    endtask

    task automatic legal(input int n, input bit clr);
        logic [W-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = '0;
            v[ph] = 1'b1;
            drive(v, clr && (i == 0), 1'b0);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare one cycle after each sample.
    exp_t me;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("phase_idx",   int'(phase_idx),   me.idx);
            chk("phase_valid", int'(phase_valid), me.valid);
            chk("locked",      int'(locked),      me.lck);
            chk("wrap_pulse",  int'(wrap_pulse),  me.wrap);
            chk("rev_count",   int'(rev_count),   me.rev);
            chk("err_onehot",  int'(err_onehot),  me.eoh);
            chk("err_skip",    int'(err_skip),    me.esk);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [W-1:0] v;
        reset = 1'b1; err_clr = 1'b0; ring_in = '0;
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
        ph = 0;
        legal(9, 1'b0);                 // lock
        legal(16, 1'b0);                // 4 revolutions, rev_count wraps at 2 bits
        drive(4'b0011, 1'b0, 1'b0);     // multi-hot while locked
        legal(3, 1'b0);                 // stays in FAULT
        legal(10, 1'b1);                // err_clr with legal stream, relock
        v = '0; v[(ph + W - 1) % W] = 1'b1;
        drive(v, 1'b0, 1'b0);           // skipped phase while locked
        legal(3, 1'b0);
        legal(10, 1'b1);
        v = '0; v[(ph + 1) % W] = 1'b1;
        drive(v, 1'b0, 1'b0);           // repeat of previous sample
        drive(v, 1'b0, 1'b0);
        legal(4, 1'b0);
        legal(10, 1'b1);
        drive('0, 1'b1, 1'b0);          // err_clr coincident with a bad sample
        legal(2, 1'b0);
        legal(12, 1'b1);
        drive('0, 1'b0, 1'b1);          // reset mid-operation
        legal(12, 1'b0);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) drive(W'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 9) == 0), 1'b0);
            else if (r < 10) drive(m_prev, 1'b0, 1'b0);
            else if (r < 11) drive('0, 1'b0, 1'b1);
            else legal(1, ($urandom_range(0, 19) == 0));
        end
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
